// File: rtl/instr_mem_loadable_pkg.sv
`default_nettype none
// ============================================================================
// Module      : instr_mem_loadable_pkg
// Description : Shared opcode constants and the loader state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package instr_mem_loadable_pkg;

    localparam logic [5:0]  OP_HALT           = 6'h1A;
    localparam logic [5:0]  OP_OUT            = 6'h1C;
    localparam logic [31:0] HALT_WORD_DEFAULT = {OP_HALT, 26'd0};
    localparam logic [31:0] OUT_WORD_DEFAULT  = {OP_OUT, 26'd0};

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_LOAD = 1'b1
    } state_e;

endpackage
`default_nettype wire

// File: rtl/instr_mem_loadable_if.sv
`default_nettype none
// ============================================================================
// Module      : instr_mem_loadable_if
// Description : Fetch and program-load bundle between core/loader and memory.
// Revision    : 1.0 - initial release
// ============================================================================
interface instr_mem_loadable_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
);
    logic [ADDR_WIDTH-1:0] read_addr;
    logic                  fetch_en;
    logic [DATA_WIDTH-1:0] q;
    logic                  q_valid;
    logic                  load_start;
    logic                  load_valid;
    logic [DATA_WIDTH-1:0] load_data;
    logic                  load_last;
    logic                  load_ready;
    logic                  load_busy;
    logic                  load_err;
    logic [ADDR_WIDTH:0]   prog_len;

    modport master (
        output read_addr, fetch_en, load_start, load_valid, load_data, load_last,
        input  q, q_valid, load_ready, load_busy, load_err, prog_len
    );

    modport slave (
        input  read_addr, fetch_en, load_start, load_valid, load_data, load_last,
        output q, q_valid, load_ready, load_busy, load_err, prog_len
    );
endinterface
`default_nettype wire

// File: rtl/instr_mem_loadable_imem_ram.sv
`default_nettype none
// ============================================================================
// Module      : imem_ram
// Description : Simple dual-port RAM, one sync write port, one sync read port.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  wire logic                  clk,
    input  wire logic                  we_i,
    input  wire logic [ADDR_WIDTH-1:0] waddr_i,
    input  wire logic [DATA_WIDTH-1:0] wdata_i,
    input  wire logic                  re_i,
    input  wire logic [ADDR_WIDTH-1:0] raddr_i,
    output      logic [DATA_WIDTH-1:0] rdata_o
);
    logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];

    // No reset on storage or read register so the array maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_o <= mem_q[raddr_i];
        end
    end
endmodule
`default_nettype wire

// File: rtl/instr_mem_loadable.sv
`default_nettype none
// ============================================================================
// Module      : instr_mem_loadable
// Description : Instruction memory with runtime program load and HALT fill.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_mem_loadable
    import instr_mem_loadable_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 10,
    parameter logic [DATA_WIDTH-1:0] HALT_WORD  = DATA_WIDTH'(HALT_WORD_DEFAULT),
    parameter int                    INIT_LEN   = 0
) (
    input wire logic           clk,
    input wire logic           reset,
    instr_mem_loadable_if.slave mem_if
);
    localparam logic [ADDR_WIDTH:0] DEPTH      = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] INIT_LEN_W = (ADDR_WIDTH+1)'(INIT_LEN);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0]   prog_len_q, prog_len_d;
    logic                  err_q, err_d;
    logic                  halt_sel_q, halt_sel_d;
    logic                  q_valid_q, q_valid_d;
    logic                  ram_we, ram_re;
    logic [DATA_WIDTH-1:0] ram_rdata;

    imem_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .waddr_i (wr_ptr_q[ADDR_WIDTH-1:0]),
        .wdata_i (mem_if.load_data),
        .re_i    (ram_re),
        .raddr_i (mem_if.read_addr),
        .rdata_o (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_RUN;
            wr_ptr_q   <= '0;
            prog_len_q <= INIT_LEN_W;
            err_q      <= 1'b0;
            halt_sel_q <= 1'b1;
            q_valid_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            prog_len_q <= prog_len_d;
            err_q      <= err_d;
            halt_sel_q <= halt_sel_d;
            q_valid_q  <= q_valid_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        prog_len_d = prog_len_q;
        err_d      = err_q;
        halt_sel_d = halt_sel_q;
        q_valid_d  = 1'b0;
        ram_we     = 1'b0;
        ram_re     = 1'b0;
        case (state_q)
            ST_RUN: begin
                // The RAM read register and halt flag both hold when idle, so q holds.
                if (mem_if.fetch_en) begin
                    ram_re     = 1'b1;
                    q_valid_d  = 1'b1;
                    halt_sel_d = ({1'b0, mem_if.read_addr} >= prog_len_q);
                end
                if (mem_if.load_start) begin
                    state_d    = ST_LOAD;
                    wr_ptr_d   = '0;
                    prog_len_d = '0;
                    err_d      = 1'b0;
                end
            end
            ST_LOAD: begin
                if (mem_if.load_valid) begin
                    if (wr_ptr_q < DEPTH) begin
                        ram_we     = 1'b1;
                        wr_ptr_d   = wr_ptr_q + 1'b1;
                        prog_len_d = wr_ptr_q + 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                    if (mem_if.load_last) begin
                        state_d = ST_RUN;
                    end
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    assign mem_if.q          = halt_sel_q ? HALT_WORD : ram_rdata;
    assign mem_if.q_valid    = q_valid_q;
    assign mem_if.load_ready = (state_q == ST_LOAD);
    assign mem_if.load_busy  = (state_q == ST_LOAD);
    assign mem_if.load_err   = err_q;
    assign mem_if.prog_len   = prog_len_q;
endmodule
`default_nettype wire

// File: doc/instr_mem_loadable.md
Name: instr_mem_loadable

Overview:
- Parametrised successor to the fixed-image instruction memory: synchronous-read instruction store whose program can be streamed in at runtime through a valid/ready load port.
- Sits between the fetch stage and an external loader (UART/debug bridge).
- Adds fetch enable with a q_valid qualifier and a program-length bound.
- Fetches at or beyond the loaded length return HALT_WORD, so a runaway PC halts the core.

Parameters:
- DATA_WIDTH, 32, instruction word width.
- ADDR_WIDTH, 10, word address width; DEPTH = 2**ADDR_WIDTH.
- HALT_WORD, 32'h6800_0000, word returned for out-of-program fetches (HALT encoding).
- INIT_LEN, 0, program length after reset, 0..DEPTH (allows a preloaded image).

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- read_addr  in  ADDR_WIDTH  fetch word address.
- fetch_en  in  1  fetch request this cycle.
- q  out  DATA_WIDTH  fetched instruction, registered.
- q_valid  out  1  q was updated by a fetch accepted on the previous edge.
- load_start  in  1  request to begin a program load.
- load_valid  in  1  load_data/load_last are valid.
- load_data  in  DATA_WIDTH  program word.
- load_last  in  1  final word of the program.
- load_ready  out  1  block accepts load beats (high only in LOAD).
- load_busy  out  1  state is LOAD.
- load_err  out  1  sticky: at least one beat was dropped for exceeding DEPTH in the current or last load.
- prog_len  out  ADDR_WIDTH+1  number of valid program words.

Behaviour:
- States:
  - RUN: fetch active.
  - LOAD: fetch blocked, load port open.
- Reset values: state RUN, q = HALT_WORD, q_valid 0, load_ready 0, load_busy 0, load_err 0, wr_ptr 0, prog_len INIT_LEN.
- RAM contents are not cleared by reset.
- Fetch (RUN, fetch_en=1): at the edge, q <= (read_addr < prog_len) ? ram[read_addr] : HALT_WORD and q_valid <= 1. Latency is 1 cycle.
- fetch_en=0, or state LOAD: q holds its value and q_valid <= 0.
- RUN->LOAD on load_start=1. At that edge:
  - wr_ptr <= 0, prog_len <= 0, load_err <= 0.
  - load_ready and load_busy go high the next cycle.
- A fetch in the same cycle as load_start is still serviced, since the state is RUN that cycle.
- load_start is ignored while in LOAD.
- A beat is accepted when load_valid & load_ready:
  - If wr_ptr < DEPTH: ram[wr_ptr] <= load_data, wr_ptr++, prog_len <= wr_ptr+1.
  - Otherwise the data is dropped, load_err <= 1 and prog_len stays at DEPTH.
- wr_ptr is ADDR_WIDTH+1 bits and saturates at DEPTH; it never wraps.
- LOAD->RUN on an accepted beat with load_last=1.
  - load_ready/load_busy drop the next cycle.
  - The first fetch is possible in that next cycle.
- A load_last beat that is dropped (overflow) still ends the load.
- load_valid while in RUN is ignored (load_ready=0; no write).
- Zero-length load is not possible: the minimum is one beat carrying load_last.
- Reset mid-load returns to RUN with prog_len=INIT_LEN. Partially written words stay in RAM; only words below INIT_LEN are fetchable.
- load_err stays set until the next load_start or reset.

Decomposition:
- Shared package (cpu_pkg): HALT and OUT opcode constants, and a state enum {RUN, LOAD}.
- One natural sub-module: imem_ram, a simple dual-port RAM with a sync read port and a sync write port, inferring block RAM.
- The top level holds the FSM, wr_ptr, prog_len, and the HALT-substitution mux.

Test Plan:
- Reset with INIT_LEN=0, then fetch addr 0 -> one cycle later q=32'h6800_0000, q_valid=1, prog_len=0.
- load_start; stream 6 words (ADDI r1,r0,5 = 32'h0420_0005; ADDI r1,r1,1 = 32'h0421_0001 x3; OUT 32'h7000_0000; HALT) with last on word 6 -> prog_len=6, load_busy drops. Fetches 0..5 return those words with 1-cycle latency; fetch 6 -> HALT_WORD.
- Toggle load_valid randomly during a load (gaps, back-to-back beats) -> only handshaked beats are written, in order, with no duplicates.
- ADDR_WIDTH=2: stream 6 beats with last on the 6th -> words 0..3 written, load_err=1, prog_len=4, state RUN; fetch 3 returns word 3.
- Fetch attempted during LOAD -> q_valid stays 0 and q holds its previous value. Assert reset after 3 accepted beats -> RUN, prog_len=INIT_LEN, load_err=0.
- load_start pulsed during LOAD and load_valid asserted in RUN -> no state change, no RAM write, prog_len unchanged.
